// File: rtl/flash_macro_sequencer_pkg.sv
// Shared constants for the flash macro sequencer: macro codes, QSPI opcodes,
// FSM state encoding and the latched request record.
package flash_pkg;

  localparam logic [3:0] FlashERS4kB = 4'hA;
  localparam logic [3:0] FlashRdID   = 4'hB;
  localparam logic [3:0] FlashWrPg   = 4'hC;
  localparam logic [3:0] FlashRdSR   = 4'hE;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_SE    = 8'h20;
  localparam logic [7:0] OP_PP    = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_RDID  = 8'h9F;
  localparam logic [7:0] OP_DUMMY = 8'h00;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WREN     = 3'd1;
  localparam logic [2:0] S_CMD      = 3'd2;
  localparam logic [2:0] S_ADDR     = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_POLL_CMD = 3'd5;
  localparam logic [2:0] S_POLL_RD  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  typedef struct packed {
    logic [3:0]  code;
    logic [23:0] addr;
  } macro_req_t;

  // Erase/program need write-enable first; reads go straight to the opcode;
  // anything else is rejected and finishes immediately with an error.
  function automatic logic [2:0] entry_state(input logic [3:0] code);
    case (code)
      FlashERS4kB, FlashWrPg: return S_WREN;
      FlashRdSR, FlashRdID:   return S_CMD;
      default:                return S_DONE;
    endcase
  endfunction

endpackage

// File: rtl/flash_macro_sequencer_if.sv
// Bundle of the macro request, program-buffer and SPI byte-engine signals
// seen by the flash macro sequencer.
interface flash_macro_sequencer_if;
  logic [3:0]  macro_states;
  logic        macro_states_valid;
  logic [31:0] addr_reg;
  logic        flash_macro_states_done;
  logic        flash_err;
  logic [7:0]  sr_reg;
  logic [23:0] id_reg;
  logic        buff_rd_en;
  logic [7:0]  buff_dout;
  logic        buff_prog_empty;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic        spi_last;
  logic        spi_busy;
  logic        spi_done;
  logic [7:0]  spi_rx;

  modport master (
    input  macro_states, macro_states_valid, addr_reg,
    input  buff_dout, buff_prog_empty,
    input  spi_busy, spi_done, spi_rx,
    output flash_macro_states_done, flash_err, sr_reg, id_reg,
    output buff_rd_en, spi_start, spi_tx, spi_last
  );

  modport slave (
    output macro_states, macro_states_valid, addr_reg,
    output buff_dout, buff_prog_empty,
    output spi_busy, spi_done, spi_rx,
    input  flash_macro_states_done, flash_err, sr_reg, id_reg,
    input  buff_rd_en, spi_start, spi_tx, spi_last
  );
endinterface

// File: rtl/flash_macro_sequencer.sv
// Turns macro codes into QSPI byte sequences on a byte-level SPI engine:
// WREN / erase / page program / status poll / JEDEC ID read.
module flash_macro_sequencer
  import flash_pkg::*;
#(
  parameter int unsigned PG_BYTES = 256,
  parameter int unsigned POLL_MAX = 24'hFFFFFF,
  parameter logic [7:0]  CMD_WREN = OP_WREN,
  parameter logic [7:0]  CMD_SE   = OP_SE,
  parameter logic [7:0]  CMD_PP   = OP_PP,
  parameter logic [7:0]  CMD_RDSR = OP_RDSR,
  parameter logic [7:0]  CMD_RDID = OP_RDID
) (
  input logic clk,
  input logic rst,
  flash_macro_sequencer_if.master bus
);

  localparam logic [8:0]  PG_LAST   = 9'(PG_BYTES - 1);
  localparam logic [23:0] POLL_LAST = 24'(POLL_MAX - 1);

  logic [2:0]  state;
  macro_req_t  req;
  logic [1:0]  byte_cnt;
  logic [8:0]  data_cnt;
  logic [23:0] poll_cnt;
  logic        pend;      // byte handed to the engine, waiting for spi_done
  logic [1:0]  fetch;     // 1: buffer read issued, 2: buff_dout valid

  logic       can_issue, xfer_done, is_write, data_last;
  logic [7:0] addr_byte, cmd_op;
  logic       unused_addr_hi;

  assign unused_addr_hi = ^bus.addr_reg[31:24];

  assign can_issue = !pend && !bus.spi_busy && !bus.spi_start;
  assign xfer_done = pend && bus.spi_done;
  assign is_write  = (req.code == FlashWrPg);
  assign addr_byte = req.addr[{byte_cnt, 3'b000} +: 8];
  // Reads reuse the data phase for dummy bytes: one for RDSR, three for RDID.
  assign data_last = is_write ? (data_cnt == PG_LAST)
                              : (data_cnt == ((req.code == FlashRdID) ? 9'd2 : 9'd0));

  always_comb begin
    cmd_op = CMD_RDSR;
    case (req.code)
      FlashERS4kB: cmd_op = CMD_SE;
      FlashWrPg:   cmd_op = CMD_PP;
      FlashRdID:   cmd_op = CMD_RDID;
      default:     cmd_op = CMD_RDSR;
    endcase
  end

  assign bus.flash_macro_states_done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      req            <= '0;
      byte_cnt       <= '0;
      data_cnt       <= '0;
      poll_cnt       <= '0;
      pend           <= 1'b0;
      fetch          <= 2'd0;
      bus.flash_err  <= 1'b0;
      bus.sr_reg     <= '0;
      bus.id_reg     <= '0;
      bus.buff_rd_en <= 1'b0;
      bus.spi_start  <= 1'b0;
      bus.spi_tx     <= '0;
      bus.spi_last   <= 1'b0;
    end else begin
      bus.spi_start  <= 1'b0;
      bus.spi_last   <= 1'b0;
      bus.buff_rd_en <= 1'b0;
      case (state)
        S_IDLE: if (bus.macro_states_valid) begin
          req           <= '{code: bus.macro_states, addr: bus.addr_reg[23:0]};
          byte_cnt      <= '0;
          data_cnt      <= '0;
          poll_cnt      <= '0;
          pend          <= 1'b0;
          fetch         <= 2'd0;
          bus.flash_err <= (entry_state(bus.macro_states) == S_DONE);
          state         <= entry_state(bus.macro_states);
        end
        S_WREN: begin
          if (can_issue) begin
            bus.spi_start <= 1'b1; bus.spi_tx <= CMD_WREN; bus.spi_last <= 1'b1; pend <= 1'b1;
          end
          if (xfer_done) begin pend <= 1'b0; state <= S_CMD; end
        end
        S_CMD: begin
          if (can_issue) begin
            bus.spi_start <= 1'b1; bus.spi_tx <= cmd_op; pend <= 1'b1;
          end
          if (xfer_done) begin
            pend     <= 1'b0;
            byte_cnt <= 2'd2;
            data_cnt <= '0;
            state    <= (req.code == FlashRdSR || req.code == FlashRdID) ? S_DATA : S_ADDR;
          end
        end
        S_ADDR: begin
          if (can_issue) begin
            bus.spi_start <= 1'b1; bus.spi_tx <= addr_byte;
            bus.spi_last  <= !is_write && (byte_cnt == 2'd0); pend <= 1'b1;
          end
          if (xfer_done) begin
            pend <= 1'b0;
            if (byte_cnt == 2'd0) state <= is_write ? S_DATA : S_POLL_CMD;
            else                  byte_cnt <= byte_cnt - 2'd1;
          end
        end
        S_DATA: begin
          if (is_write) begin
            // An empty buffer simply stalls here with CS still asserted.
            if (can_issue && fetch == 2'd0 && !bus.buff_prog_empty) begin
              bus.buff_rd_en <= 1'b1; fetch <= 2'd1;
            end
            if (fetch == 2'd1) fetch <= 2'd2;
            if (fetch == 2'd2) begin
              bus.spi_start <= 1'b1; bus.spi_tx <= bus.buff_dout;
              bus.spi_last  <= data_last; pend <= 1'b1; fetch <= 2'd0;
            end
          end else if (can_issue) begin
            bus.spi_start <= 1'b1; bus.spi_tx <= OP_DUMMY; bus.spi_last <= data_last; pend <= 1'b1;
          end
          if (xfer_done) begin
            pend <= 1'b0;
            if (req.code == FlashRdSR) bus.sr_reg <= bus.spi_rx;
            if (req.code == FlashRdID) bus.id_reg <= {bus.id_reg[15:0], bus.spi_rx};
            if (data_last) state <= is_write ? S_POLL_CMD : S_DONE;
            else           data_cnt <= data_cnt + 9'd1;
          end
        end
        S_POLL_CMD: begin
          if (can_issue) begin
            bus.spi_start <= 1'b1; bus.spi_tx <= CMD_RDSR; pend <= 1'b1;
          end
          if (xfer_done) begin pend <= 1'b0; state <= S_POLL_RD; end
        end
        S_POLL_RD: begin
          if (can_issue) begin
            bus.spi_start <= 1'b1; bus.spi_tx <= OP_DUMMY; bus.spi_last <= 1'b1; pend <= 1'b1;
          end
          if (xfer_done) begin
            pend       <= 1'b0;
            bus.sr_reg <= bus.spi_rx;
            if (!bus.spi_rx[0]) begin
              state <= S_DONE;
            end else if (poll_cnt == POLL_LAST) begin
              bus.flash_err <= 1'b1;
              state         <= S_DONE;
            end else begin
              poll_cnt <= poll_cnt + 24'd1;
              state    <= S_POLL_CMD;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_macro_sequencer.sv
// Directed bench: byte-level SPI engine and program-buffer models, a table of
// macro vectors, plus hand sequences for buffer stall, busy strobes and reset.
module tb_flash_macro_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_macro_sequencer_if bif();
  flash_macro_sequencer #(.POLL_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bif));

  int errors = 0;
  int checks = 0;

  // ---------------- models ----------------
  logic       tb_clr = 1'b0;
  logic [7:0] sr_tab [8];
  int         sr_n = 0;
  logic [23:0] id_model = '0;
  logic [7:0] mem [256];
  int         avail = 0;

  logic [8:0] log_q [$];
  int start_cnt = 0, last_cnt = 0, bad_start = 0, done_cnt = 0, rd_cnt = 0;
  int idx = 0, cnt = 0, sr_rd = 0, rp = 0;
  logic [7:0] op = '0;
  logic cur_last = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bif.spi_busy <= 1'b0; bif.spi_done <= 1'b0; bif.spi_rx <= '0;
      idx <= 0; cnt <= 0; cur_last <= 1'b0; op <= '0;
    end else begin
      bif.spi_done <= 1'b0;
      if (tb_clr) sr_rd <= 0;
      if (bif.spi_start) begin
        if (bif.spi_busy) bad_start <= bad_start + 1;
        start_cnt <= start_cnt + 1;
        if (bif.spi_last) last_cnt <= last_cnt + 1;
        log_q.push_back({bif.spi_last, bif.spi_tx});
        if (idx == 0) op <= bif.spi_tx;
        bif.spi_busy <= 1'b1; cnt <= 3; cur_last <= bif.spi_last;
      end else if (bif.spi_busy) begin
        if (cnt == 0) begin
          bif.spi_busy <= 1'b0; bif.spi_done <= 1'b1;
          idx <= cur_last ? 0 : idx + 1;
          if (op == 8'h05 && idx == 1) begin
            bif.spi_rx <= (sr_rd < sr_n) ? sr_tab[sr_rd] : 8'h00;
            sr_rd <= sr_rd + 1;
          end else if (op == 8'h9F && idx >= 1 && idx <= 3) begin
            bif.spi_rx <= id_model[8*(3-idx) +: 8];
          end else begin
            bif.spi_rx <= 8'h00;
          end
        end else cnt <= cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (tb_clr) rp <= 0;
    else if (bif.buff_rd_en) begin
      bif.buff_dout <= mem[rp[7:0]]; rp <= rp + 1; rd_cnt <= rd_cnt + 1;
    end
    if (bif.flash_macro_states_done) done_cnt <= done_cnt + 1;
  end
  assign bif.buff_prog_empty = (rp >= avail);

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr_models();
    @(negedge clk) tb_clr = 1'b1;
    @(negedge clk) tb_clr = 1'b0;
  endtask

  task automatic start_macro(input logic [3:0] code, input logic [31:0] addr);
    @(negedge clk);
    bif.macro_states = code; bif.addr_reg = addr; bif.macro_states_valid = 1'b1;
    @(negedge clk) bif.macro_states_valid = 1'b0;
  endtask

  // Waits for a done pulse, then confirms exactly one pulse was produced.
  task automatic wait_done(input string name, input int snap);
    int t = 0;
    while (done_cnt == snap && t < 6000) begin @(negedge clk); t++; end
    if (t >= 6000) chk({name, "_timeout"}, 32'd1, 32'd0);
    repeat (5) @(negedge clk);
    chk({name, "_done_pulses"}, 32'(done_cnt - snap), 32'd1);
  endtask

  function automatic logic [9:0] B(input logic l, input logic [7:0] d);
    return {1'b1, l, d};
  endfunction
  localparam logic [9:0] XL = 10'b01_0000_0000;
  localparam logic [9:0] X0 = 10'b00_0000_0000;

  // Compares logged bytes against a care/last/data expectation.
  task automatic chk_byte(input string name, input int pos, input logic [9:0] e);
    logic [9:0] a;
    a = 10'h3FF;
    if (pos < log_q.size()) a = e[9] ? {1'b1, log_q[pos]} : {1'b0, log_q[pos][8], 8'h00};
    chk(name, {22'd0, a}, {22'd0, e});
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]        code;
    logic [31:0]       addr;
    logic [3:0]        n_sr;
    logic [3:0][7:0]   sr;
    logic [23:0]       id;
    logic [3:0]        n_exp;
    logic [13:0][9:0]  exp;
    logic              exp_err;
    logic [7:0]        exp_sr;
    logic [23:0]       exp_id;
  } vec_t;

  vec_t vecs [6];
  vec_t v;
  int   k;

  task automatic vnew(input logic [3:0] code, input logic [31:0] addr);
    v = '0; k = 0; v.code = code; v.addr = addr;
  endtask
  task automatic vadd(input logic [9:0] e);
    v.exp[k] = e; k++; v.n_exp = 4'(k);
  endtask
  task automatic ers_hdr(input logic [31:0] a);
    vadd(B(1, 8'h06)); vadd(B(0, 8'h20));
    vadd(B(0, a[23:16])); vadd(B(0, a[15:8])); vadd(B(1, a[7:0]));
  endtask
  task automatic poll_round();
    vadd(B(0, 8'h05)); vadd(XL);
  endtask

  initial begin
    int base, s0, l0, r0, bad;
    bif.macro_states = '0; bif.macro_states_valid = 1'b0; bif.addr_reg = '0;
    for (int i = 0; i < 8; i++) sr_tab[i] = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    vnew(4'hA, 32'h0000_1000); ers_hdr(32'h0000_1000);
    poll_round(); poll_round(); poll_round();
    v.n_sr = 3; v.sr[0] = 8'h03; v.sr[1] = 8'h03; v.sr[2] = 8'h00;
    v.exp_err = 0; v.exp_sr = 8'h00; v.exp_id = 24'h0; vecs[0] = v;

    vnew(4'hB, 32'h0); vadd(B(0, 8'h9F)); vadd(X0); vadd(X0); vadd(XL);
    v.id = 24'hEF4018; v.exp_err = 0; v.exp_sr = 8'h00; v.exp_id = 24'hEF4018; vecs[1] = v;

    vnew(4'hE, 32'h0); vadd(B(0, 8'h05)); vadd(XL);
    v.n_sr = 1; v.sr[0] = 8'h5C; v.exp_err = 0; v.exp_sr = 8'h5C; v.exp_id = 24'hEF4018; vecs[2] = v;

    vnew(4'h3, 32'h0);
    v.exp_err = 1; v.exp_sr = 8'h5C; v.exp_id = 24'hEF4018; vecs[3] = v;

    vnew(4'hA, 32'h1234_5678); ers_hdr(32'h1234_5678); poll_round();
    v.n_sr = 1; v.sr[0] = 8'h00; v.exp_err = 0; v.exp_sr = 8'h00; v.exp_id = 24'hEF4018; vecs[4] = v;

    vnew(4'hA, 32'h0); ers_hdr(32'h0);
    poll_round(); poll_round(); poll_round(); poll_round();
    v.n_sr = 4; v.sr = {4{8'h01}}; v.exp_err = 1; v.exp_sr = 8'h01; v.exp_id = 24'hEF4018; vecs[5] = v;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, bif.flash_macro_states_done}, 32'd0);
    chk("rst_err", {31'd0, bif.flash_err}, 32'd0);
    chk("rst_spi", {29'd0, bif.spi_start, bif.spi_last, bif.buff_rd_en}, 32'd0);
    chk("rst_sr_id", {bif.sr_reg, bif.id_reg}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- table-driven macros ----
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      for (int j = 0; j < 4; j++) sr_tab[j] = v.sr[j];
      sr_n = int'(v.n_sr); id_model = v.id;
      clr_models();
      base = log_q.size(); s0 = done_cnt;
      start_macro(v.code, v.addr);
      wait_done($sformatf("v%0d", i), s0);
      chk($sformatf("v%0d_nbytes", i), 32'(log_q.size() - base), {28'd0, v.n_exp});
      for (int j = 0; j < int'(v.n_exp); j++)
        chk_byte($sformatf("v%0d_b%0d", i, j), base + j, v.exp[j]);
      chk($sformatf("v%0d_err", i), {31'd0, bif.flash_err}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_sr", i), {24'd0, bif.sr_reg}, {24'd0, v.exp_sr});
      chk($sformatf("v%0d_id", i), {8'd0, bif.id_reg}, {8'd0, v.exp_id});
    end

    // ---- reset in the middle of the address phase ----
    sr_n = 0; clr_models();
    base = log_q.size();
    start_macro(4'hA, 32'h00AB_CDEF);
    for (int t = 0; t < 500 && log_q.size() - base < 3; t++) @(negedge clk);
    chk("mid_rst_reached_addr", 32'(log_q.size() - base), 32'd3);
    l0 = last_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {28'd0, bif.spi_start, bif.spi_last, bif.buff_rd_en,
                         bif.flash_macro_states_done}, 32'd0);
    chk("mid_rst_err_sr", {23'd0, bif.flash_err, bif.sr_reg}, 32'd0);
    chk("mid_rst_id", {8'd0, bif.id_reg}, 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_last", 32'(last_cnt - l0), 32'd0);
    sr_n = 1; sr_tab[0] = 8'h00; clr_models();
    base = log_q.size(); s0 = done_cnt;
    start_macro(4'hA, 32'h0000_4000);
    wait_done("post_rst", s0);
    chk("post_rst_nbytes", 32'(log_q.size() - base), 32'd7);
    chk_byte("post_rst_b1", base + 1, B(0, 8'h20));
    chk_byte("post_rst_b3", base + 3, B(0, 8'h40));
    chk_byte("post_rst_b4", base + 4, B(1, 8'h00));
    chk("post_rst_err", {31'd0, bif.flash_err}, 32'd0);

    // ---- page program, buffer full ----
    avail = 256; sr_n = 2; sr_tab[0] = 8'h01; sr_tab[1] = 8'h00; clr_models();
    base = log_q.size(); s0 = done_cnt; r0 = rd_cnt;
    start_macro(4'hC, 32'h0002_0000);
    wait_done("wrpg", s0);
    chk("wrpg_nbytes", 32'(log_q.size() - base), 32'd265);
    chk_byte("wrpg_b0", base + 0, B(1, 8'h06));
    chk_byte("wrpg_b1", base + 1, B(0, 8'h02));
    chk_byte("wrpg_b2", base + 2, B(0, 8'h02));
    chk_byte("wrpg_b3", base + 3, B(0, 8'h00));
    chk_byte("wrpg_b4", base + 4, B(0, 8'h00));
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (base + 5 + i >= log_q.size() || log_q[base + 5 + i] !== {i == 255, 8'(i)}) bad++;
    chk("wrpg_data_bytes_bad", 32'(bad), 32'd0);
    chk_byte("wrpg_poll", base + 261, B(0, 8'h05));
    chk("wrpg_rd_pulses", 32'(rd_cnt - r0), 32'd256);
    chk("wrpg_err", {31'd0, bif.flash_err}, 32'd0);

    // ---- page program, buffer runs dry after 100 bytes ----
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    avail = 100; sr_n = 1; sr_tab[0] = 8'h00; clr_models();
    base = log_q.size(); s0 = done_cnt; r0 = rd_cnt;
    start_macro(4'hC, 32'h0003_0100);
    for (int t = 0; t < 3000 && (log_q.size() - base < 105 || bif.spi_busy); t++) @(negedge clk);
    repeat (5) @(negedge clk);
    l0 = last_cnt; k = start_cnt;
    repeat (50) @(negedge clk);
    chk("stall_no_start", 32'(start_cnt - k), 32'd0);
    chk("stall_no_last", 32'(last_cnt - l0), 32'd0);
    chk("stall_bytes_sent", 32'(log_q.size() - base), 32'd105);
    chk("stall_no_done", 32'(done_cnt - s0), 32'd0);
    avail = 256;
    wait_done("stall", s0);
    chk("stall_nbytes", 32'(log_q.size() - base), 32'd263);
    chk_byte("stall_resume_b100", base + 105, B(0, 8'd100 ^ 8'h5A));
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (base + 5 + i >= log_q.size() || log_q[base + 5 + i] !== {i == 255, 8'(i) ^ 8'h5A}) bad++;
    chk("stall_data_bytes_bad", 32'(bad), 32'd0);
    chk("stall_rd_pulses", 32'(rd_cnt - r0), 32'd256);

    // ---- request strobe while busy is ignored ----
    sr_n = 2; sr_tab[0] = 8'h01; sr_tab[1] = 8'h00; clr_models();
    base = log_q.size(); s0 = done_cnt;
    start_macro(4'hA, 32'h0000_3000);
    repeat (20) @(negedge clk);
    bif.macro_states = 4'h3; bif.addr_reg = 32'hFFFF_FFFF; bif.macro_states_valid = 1'b1;
    @(negedge clk) bif.macro_states_valid = 1'b0;
    wait_done("busy_strobe", s0);
    repeat (20) @(negedge clk);
    chk("busy_strobe_no_extra_done", 32'(done_cnt - s0), 32'd1);
    chk("busy_strobe_err", {31'd0, bif.flash_err}, 32'd0);
    chk("busy_strobe_nbytes", 32'(log_q.size() - base), 32'd9);
    chk_byte("busy_strobe_b3", base + 3, B(0, 8'h30));

    chk("start_while_busy", 32'(bad_start), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
